// File: rtl/bus8088_pkg.sv
// Shared types for the 8088-style bus initiator: one-hot bus state,
// captured request record and the fixed bus widths.
// No logic; imported by bus_initiator_8088.
package bus8088_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    // One-hot bus cycle states. TW is only reachable when wait states are enabled.
    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        T4   = 6'b010000,
        TW   = 6'b100000
    } bus_state_t;

    typedef struct packed {
        logic              write;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_initiator_8088.sv
// Purpose: minimum-mode 8088-style bus master running one T1-T4 byte cycle per host request.
// Latency: handshake to rsp_valid is 5 cycles (plus one per TW cycle when wait states are enabled).
// Backpressure: req_ready is high only in IDLE; one transfer in flight, max one per 5 cycles.
//
// Ports: CLK/RESET (async active-low); host side req_valid/req_ready/req_write/req_io/
// req_addr/req_wdata, response rsp_valid/rsp_rdata; bus side ALE, IOM, RD (low), WR (low),
// CS, A[19:8], AD[7:0] (tri-state, address/data multiplexed).
// Build option: define BUS_WAIT_STATE_EN to add the READY input and the TW wait state.
module bus_initiator_8088
    import bus8088_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_io,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
`ifdef BUS_WAIT_STATE_EN
    input  logic                     READY,
`endif
    output logic                     ALE,
    output logic                     IOM,
    output logic                     RD,
    output logic                     WR,
    output logic                     CS,
    output logic [ADDR_W-DATA_W-1:0] A,
    inout  wire  [DATA_W-1:0]        AD
);

    bus_state_t               state_q, state_d;
    bus_req_t                 req_q, req_d;
    logic                     ale_q, ale_d;
    logic                     iom_q, iom_d;
    logic                     rd_n_q, rd_n_d;
    logic                     wr_n_q, wr_n_d;
    logic                     cs_q, cs_d;
    logic [ADDR_W-DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0]        ad_out_q, ad_out_d;
    logic                     ad_oe_q, ad_oe_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic                     handshake;

    always_comb begin
        handshake = req_valid && req_ready_q;

        req_d = req_q;
        if (handshake) begin
            req_d = {req_write, req_io, req_addr, req_wdata};
        end

        state_d = state_q;
        case (state_q)
            IDLE: if (handshake) state_d = T1;
            T1:   state_d = T2;
            T2:   state_d = T3;
`ifdef BUS_WAIT_STATE_EN
            T3:   state_d = READY ? T4 : TW;
            TW:   state_d = READY ? T4 : TW;
`else
            T3:   state_d = T4;
`endif
            T4:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus outputs are decoded from the state being entered and registered,
        // so every pin changes cleanly on the clock edge with no host-to-pin path.
        ale_d    = 1'b0;
        cs_d     = 1'b0;
        iom_d    = 1'b0;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d      = '0;
        ad_out_d = '0;
        ad_oe_d  = 1'b0;
        case (state_d)
            T1: begin
                cs_d     = 1'b1;
                ale_d    = 1'b1;
                iom_d    = req_d.io;
                a_d      = req_d.addr[ADDR_W-1:DATA_W];
                ad_out_d = req_d.addr[DATA_W-1:0];
                ad_oe_d  = 1'b1;
            end
            T2: begin
                cs_d     = 1'b1;
                iom_d    = req_d.io;
                a_d      = req_d.addr[ADDR_W-1:DATA_W];
                ad_out_d = req_d.addr[DATA_W-1:0];
                ad_oe_d  = 1'b1;
                rd_n_d   = req_d.write;
                wr_n_d   = !req_d.write;
            end
            T3, TW: begin
                cs_d     = 1'b1;
                iom_d    = req_d.io;
                a_d      = req_d.addr[ADDR_W-1:DATA_W];
                ad_out_d = req_d.wdata;
                ad_oe_d  = req_d.write;
                rd_n_d   = req_d.write;
                wr_n_d   = !req_d.write;
            end
            T4: begin
                // Strobes released; write data held one more cycle for hold time.
                cs_d     = 1'b1;
                iom_d    = req_d.io;
                a_d      = req_d.addr[ADDR_W-1:DATA_W];
                ad_out_d = req_d.wdata;
                ad_oe_d  = req_d.write;
            end
            default: ;
        endcase

        req_ready_d = (state_d == IDLE);
        // T4 always returns to IDLE, so the response pulse marks the first IDLE cycle.
        rsp_valid_d = (state_q == T4);
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == T4 && !req_q.write) begin
            rsp_rdata_d = AD;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            req_q       <= '0;
            ale_q       <= 1'b0;
            iom_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            cs_q        <= 1'b0;
            a_q         <= '0;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ale_q       <= ale_d;
            iom_q       <= iom_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            cs_q        <= cs_d;
            a_q         <= a_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign AD        = ad_oe_q ? ad_out_q : {DATA_W{1'bz}};
    assign ALE       = ale_q;
    assign IOM       = iom_q;
    assign RD        = rd_n_q;
    assign WR        = wr_n_q;
    assign CS        = cs_q;
    assign A         = a_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/bus_initiator_8088.md
Name: bus_initiator_8088

Overview:
- Minimum-mode 8088-style bus initiator. It is the master end of the multiplexed ALE/IOM/RD/WR/CS/A/AD bus served by the team's memory/IO responder.
- It accepts one byte-transfer request at a time from a host-side valid/ready port and runs a T1-T4 bus cycle.
- For reads, it returns the sampled byte on a one-cycle response strobe.
- It sits between the CPU model or testbench driver and the responder instances.

Parameters:
- ADDR_W, 20, bus address width. Fixed to 20; A carries [19:8], AD carries [7:0].
- DATA_W, 8, data width. Fixed to 8.

Ports:
- CLK  input  1  clock; all state changes on posedge
- RESET  input  1  asynchronous, active-low reset
- req_valid  input  1  host request present
- req_ready  output  1  initiator can accept a request
- req_write  input  1  1 = write cycle, 0 = read cycle
- req_io  input  1  1 = IO cycle, 0 = memory cycle
- req_addr  input  20  byte address
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle pulse marking a completed cycle
- rsp_rdata  output  8  read data; held until the next rsp_valid
- ALE  output  1  address latch enable, active-high
- IOM  output  1  IO/memory select; driven from req_io
- RD  output  1  read strobe, active-low
- WR  output  1  write strobe, active-low
- CS  output  1  chip select, active-high for the whole bus cycle
- A  output  12  address bits [19:8]
- AD  inout  8  multiplexed address [7:0] / data

Behaviour:
- Reset (RESET=0, asynchronous) forces, immediately:
  - state = IDLE
  - ALE=0, RD=1, WR=1, CS=0, IOM=0, A=0, AD=high-Z
  - req_ready=0, rsp_valid=0, rsp_rdata=0
- In-flight request on reset: abandoned, no response issued.
- After RESET deasserts, the first posedge leaves the block in IDLE with req_ready=1.
- Request acceptance:
  - Handshake occurs when req_valid && req_ready at a posedge.
  - On handshake, write/io/addr/wdata are captured into internal registers. Host inputs are don't-care afterwards.
  - req_ready=1 only in IDLE.
- State machine (one-hot enum IDLE, T1, T2, T3, T4):
  - IDLE -> T1 on handshake, else stay in IDLE.
  - T1 -> T2 -> T3 -> T4 -> IDLE unconditionally.
- Outputs per state (all registered or decoded from state; no glitching combinational paths from host inputs):
  - T1: CS=1, ALE=1, IOM=io, A=addr[19:8], AD=addr[7:0].
  - T2: CS=1, ALE=0, A and AD still hold the address. RD=0 if read, WR=0 if write. The responder latches the address and decodes the strobe in this cycle.
  - T3, read: RD=0, AD=high-Z.
  - T3, write: WR=0, AD=wdata.
  - T4, read: RD=1, AD=high-Z; AD is sampled into rsp_rdata at the posedge ending T4.
  - T4, write: WR=1, AD=wdata held for hold time.
  - T4 -> IDLE, both directions: CS=0 and A=0 on entering IDLE.
- Response:
  - rsp_valid pulses for exactly one cycle in the IDLE cycle following T4.
  - The pulse occurs for writes as well; rsp_rdata is unchanged by writes.
- Latency: handshake to rsp_valid is 5 cycles.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high. Maximum throughput is one transfer per 5 cycles.
- Mutual exclusion: RD and WR are never both 0. AD is driven only in T1, T2, and in T3/T4 of writes.
- Address wrap: none. Address 20'hFFFFF is a legal transfer; there is no increment logic.

Optional Feature:
- Macro: BUS_WAIT_STATE_EN.
- Defined:
  - Adds input READY (1 bit, active-high).
  - READY is sampled at the posedge ending T3. If READY=0, enter TW; stay in TW while READY=0, then go to T4.
  - In TW, outputs are identical to T3.
  - Latency becomes 5 + number of TW cycles.
- Undefined: no READY port and no TW state; T3 -> T4 always.

Decomposition:
- Package bus8088_pkg contains:
  - bus_state_t one-hot enum (IDLE, T1, T2, T3, T4, TW)
  - bus_req_t packed struct {write, io, addr[19:0], wdata[7:0]}
  - ADDR_W and DATA_W constants
- No sub-module: a single FSM with request register and AD tri-state assign.

Test Plan:
- Memory write: addr 20'h1_2345, wdata 8'hA5, io=0 -> T1 has A=12'h123, AD=8'h45, ALE=1. T2 has WR=0. T3 has AD=8'hA5. rsp_valid 5 cycles after handshake.
- Read-back against the responder model at the same address -> RD=0 in T2/T3, AD high-Z from T3, rsp_rdata=8'hA5.
- IO read: req_io=1, addr 20'h0_0080 -> IOM=1 throughout T1-T4, RD and WR never both 0, rsp_valid once.
- Back-to-back: req_valid held high for 3 writes to 20'h00010/11/12 -> handshakes at cycles 0, 5, 10; no idle gap beyond the response IDLE cycle.
- Reset mid-cycle: assert RESET=0 during T3 of a write -> WR=1, CS=0, AD=high-Z in the same cycle with no clock edge; no rsp_valid; req_ready=1 one cycle after release.
- BUS_WAIT_STATE_EN with READY low for 3 cycles on a read -> 3 TW cycles, RD held 0, rsp_valid at handshake+8, data sampled at the end of T4.
